// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the serial adder/subtractor.
package adder_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 2;

  function automatic int num_chunks(input int width, input int chunk);
    return width / chunk;
  endfunction

  function automatic bit cfg_ok(input int width, input int chunk);
    return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit ripple slice; c_msb is the carry into the top bit.
module adder_chunk #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             c_in,
  output logic [CHUNK-1:0] s,
  output logic             c_out,
  output logic             c_msb
);

  always_comb begin
    logic c;
    c     = c_in;
    s     = '0;
    c_msb = 1'b0;
    for (int i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) c_msb = c;
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    c_out = c;
  end

endmodule

// File: rtl/adder_serial.sv
// Multi-cycle adder/subtractor, CHUNK bits per clock, LS chunk first.
// Define ADDER_SERIAL_OVF_EN to add the signed-overflow output ovf.
module adder_serial
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out
`ifdef ADDER_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = num_chunks(WIDTH, CHUNK);
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  if (!cfg_ok(WIDTH, CHUNK)) begin : g_cfg_check
    $error("adder_serial: WIDTH must be a positive multiple of CHUNK");
  end

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_s;
  logic [KW-1:0]    r_k;
  logic             r_carry, r_cout;
  logic [CHUNK-1:0] w_a_chunk, w_b_chunk, w_sum;
  logic             w_cout, w_c_msb, w_accept, w_last;

  assign in_ready  = (r_state == IDLE) && rst_n;
  assign out_valid = (r_state == DONE);
  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_k == K_LAST);
  assign s         = r_s;
  assign c_out     = r_cout;

  always_comb begin
    w_a_chunk = r_a[int'(r_k) * CHUNK +: CHUNK];
    w_b_chunk = r_b[int'(r_k) * CHUNK +: CHUNK];
  end

  adder_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a     (w_a_chunk),
    .b     (w_b_chunk),
    .c_in  (r_carry),
    .s     (w_sum),
    .c_out (w_cout),
    .c_msb (w_c_msb)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand latches carry no reset: they are only read after an accept.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a <= a;
      r_b <= b ^ {WIDTH{sub}};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_k     <= '0;
      r_carry <= 1'b0;
      r_s     <= '0;
      r_cout  <= 1'b0;
    end else if (r_state == IDLE) begin
      if (w_accept) begin
        r_carry <= c_in;
        r_k     <= '0;
      end
    end else if (r_state == RUN) begin
      r_s[int'(r_k) * CHUNK +: CHUNK] <= w_sum;
      r_carry                         <= w_cout;
      r_k                             <= r_k + 1'b1;
      if (w_last) r_cout <= w_cout;
    end
  end

`ifdef ADDER_SERIAL_OVF_EN
  logic r_ovf;
  assign ovf = r_ovf;

  always_ff @(posedge clk) begin
    if (!rst_n)                          r_ovf <= 1'b0;
    else if (r_state == RUN && w_last)   r_ovf <= w_c_msb ^ w_cout;
  end
`else
  logic w_unused_c_msb;
  assign w_unused_c_msb = w_c_msb;
`endif

endmodule

// File: tb/tb_adder_serial.sv
// Directed bench for adder_serial: 16/2 instance plus an exhaustive 2/2 instance.
module tb_adder_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, c_in, sub, out_valid, out_ready, c_out;
  logic [15:0] a, b, s;
  logic        in_valid2, in_ready2, c_in2, sub2, out_valid2, out_ready2, c_out2;
  logic [1:0]  a2, b2, s2;
`ifdef ADDER_SERIAL_OVF_EN
  logic        ovf, ovf2;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  adder_serial #(.WIDTH(16), .CHUNK(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .s(s), .c_out(c_out)
`ifdef ADDER_SERIAL_OVF_EN
    , .ovf(ovf)
`endif
  );

  adder_serial #(.WIDTH(2), .CHUNK(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .c_in(c_in2), .sub(sub2), .out_valid(out_valid2),
    .out_ready(out_ready2), .s(s2), .c_out(c_out2)
`ifdef ADDER_SERIAL_OVF_EN
    , .ovf(ovf2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one operation (caller is #1 after an edge with in_ready high), wait for out_valid.
  task automatic run_op(input logic [15:0] ia, input logic [15:0] ib,
                        input logic icin, input logic isub, output int lat);
    a = ia; b = ib; c_in = icin; sub = isub; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic run_op2(input logic [1:0] ia, input logic [1:0] ib,
                         input logic icin, input logic isub, output int lat);
    a2 = ia; b2 = ib; c_in2 = icin; sub2 = isub; in_valid2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    lat = 0;
    while (!out_valid2 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, cnt, e;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b0;
    in_valid2 = 1'b0; a2 = '0; b2 = '0; c_in2 = 1'b0; sub2 = 1'b0; out_ready2 = 1'b0;

    // Reset held for two edges
    tick();
    check("rst_in_ready_low_1", in_ready, 1'b0);
    tick();
    check("rst_in_ready_low_2", in_ready, 1'b0);
    check("rst_s", s, 16'h0000);
    check("rst_c_out", c_out, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready_high", in_ready, 1'b1);
    tick();

    // Carry propagates across all eight chunks
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
    check("carry_latency", lat, 8);
    check("carry_s", s, 16'h0000);
    check("carry_c_out", c_out, 1'b1);
    take_result();
    check("carry_handoff_out_valid", out_valid, 1'b0);
    check("carry_handoff_in_ready", in_ready, 1'b1);

    // Subtract with and without borrow
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, lat);
    check("sub_borrow_s", s, 16'hFFFE);
    check("sub_borrow_c_out", c_out, 1'b0);
    take_result();
    run_op(16'h1234, 16'h0234, 1'b1, 1'b1, lat);
    check("sub_noborrow_s", s, 16'h1000);
    check("sub_noborrow_c_out", c_out, 1'b1);
    take_result();

    // Backpressure in DONE with ignored input pulses
    run_op(16'h00F0, 16'h0F0F, 1'b0, 1'b0, lat);
    check("bp_latency", lat, 8);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      a = 16'(i * 16'h1111);
      b = 16'h7777;
      tick();
      check($sformatf("bp_s_%0d", i), s, 16'h0FFF);
      check($sformatf("bp_c_out_%0d", i), c_out, 1'b0);
      check($sformatf("bp_out_valid_%0d", i), out_valid, 1'b1);
      check($sformatf("bp_in_ready_%0d", i), in_ready, 1'b0);
    end
    // Offer a new op in the same cycle as the handoff: accepted only one cycle later
    a = 16'h0003; b = 16'h0004; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_out_valid", out_valid, 1'b0);
    check("bp_release_in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    check("bp_accept_in_ready", in_ready, 1'b0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check("bp_next_latency", lat, 8);
    check("bp_next_s", s, 16'h0007);
    take_result();

    // Reset while chunk k=3 is next
    a = 16'hAAAA; b = 16'h5555; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_s", s, 16'h0000);
    check("midrst_c_out", c_out, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) cnt++;
    end
    check("midrst_no_out_valid", cnt, 0);
    run_op(16'h0003, 16'h0004, 1'b0, 1'b0, lat);
    check("midrst_new_latency", lat, 8);
    check("midrst_new_s", s, 16'h0007);
    check("midrst_new_c_out", c_out, 1'b0);
    take_result();

`ifdef ADDER_SERIAL_OVF_EN
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat);
    check("ovf_pos_s", s, 16'h8000);
    check("ovf_pos_flag", ovf, 1'b1);
    take_result();
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, lat);
    check("ovf_none_s", s, 16'h0002);
    check("ovf_none_flag", ovf, 1'b0);
    take_result();
`endif

    // Minimum size: exhaustive add and subtract on the 2-bit instance
    for (int isub = 0; isub < 2; isub++) begin
      for (int ia = 0; ia < 4; ia++) begin
        for (int ib = 0; ib < 4; ib++) begin
          for (int ic = 0; ic < 2; ic++) begin
            run_op2(2'(ia), 2'(ib), 1'(ic), 1'(isub), lat);
            e = ia + ((isub != 0) ? (3 - ib) : ib) + ic;
            check($sformatf("w2_lat sub=%0d a=%0d b=%0d c=%0d", isub, ia, ib, ic), lat, 1);
            check($sformatf("w2_s sub=%0d a=%0d b=%0d c=%0d", isub, ia, ib, ic), s2, e % 4);
            check($sformatf("w2_cout sub=%0d a=%0d b=%0d c=%0d", isub, ia, ib, ic), c_out2, e / 4);
            out_ready2 = 1'b1;
            tick();
            out_ready2 = 1'b0;
          end
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
